// File: rtl/seq_signed_multiplier.sv
// Multi-cycle signed 8x8->16 multiplier: magnitude shift-add over 8 RUN cycles,
// then a single SIGN cycle that applies the two's-complement sign correction.
module seq_signed_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t      state, state_nxt;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic        neg;

  // |-128| stays 0x80 when read as unsigned, so no extra width is needed.
  function automatic logic [7:0] abs8(input logic [7:0] x);
    return x[7] ? (~x + 8'd1) : x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 3'd7) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand  <= {8'b0, abs8(a)};
          mplier <= abs8(b);
          neg    <= a[7] ^ b[7];
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
        end
        SIGN: begin
          // Negating 0 gives 0 again, so a zero product never shows as -0.
          result <= neg ? (~acc + 16'd1) : acc;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
